// File: rtl/doy_pkg.sv
// ---------------------------------------------------------------------------
// doy_pkg
// Shared definitions for the day-of-year to calendar-date converter:
//   state_t       - converter FSM states (IDLE, WALK)
//   MONTH_LEN     - non-leap month lengths, January in element 0
//   DAYS_NONLEAP  - number of days in a non-leap year
//   month_len()   - length of month m (1..12), February extended by leap
// ---------------------------------------------------------------------------
package doy_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WALK = 1'b1
   } state_t;

   localparam int DAYS_NONLEAP = 365;

   // Element 0 is January, element 11 is December.
   localparam logic [11:0][4:0] MONTH_LEN = {
      5'd31, 5'd30, 5'd31, 5'd30, 5'd31, 5'd31,
      5'd30, 5'd31, 5'd30, 5'd31, 5'd28, 5'd31
   };

   // Length in days of month m; out-of-range m returns 31 so that a
   // stray month index can never shrink the subtraction below rem.
   function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
      logic [3:0] idx;
      logic [4:0] len;
      idx = m - 4'd1;
      if ((m >= 4'd1) && (m <= 4'd12)) begin
         len = MONTH_LEN[idx];
         if ((m == 4'd2) && leap) begin
            len = len + 5'd1;
         end else begin
            len = len;
         end
      end else begin
         len = 5'd31;
      end
      return len;
   endfunction

endpackage

// File: rtl/date_bcd_split.sv
// ---------------------------------------------------------------------------
// date_bcd_split
// Splits a binary month (1..12) and day-of-month (1..31) into four decimal
// digit codes. Both values are at most 31, so tens digits come from
// threshold compares rather than a divider. month==0 marks "no valid
// result" and blanks all four digits.
// Ports:
//   month       in  4  binary month, 0 = blank
//   dom         in  5  binary day-of-month
//   month_tens  out 4  digit code for HEX3
//   month_units out 4  digit code for HEX2
//   dom_tens    out 4  digit code for HEX1
//   dom_units   out 4  digit code for HEX0
// ---------------------------------------------------------------------------
module date_bcd_split #(
   parameter logic [3:0] BLANK_CODE = 4'hF
) (
   input  logic [3:0] month,
   input  logic [4:0] dom,
   output logic [3:0] month_tens,
   output logic [3:0] month_units,
   output logic [3:0] dom_tens,
   output logic [3:0] dom_units
);

   logic       mt_s;
   logic [1:0] dt_s;
   logic [3:0] doff_s;

   // Tens digits by threshold compare; doff_s is 10*tens modulo 16, which
   // is enough because the units result always fits in 4 bits.
   always_comb begin
      mt_s   = (month >= 4'd10);
      dt_s   = 2'd0;
      doff_s = 4'd0;
      if (dom >= 5'd30) begin
         dt_s   = 2'd3;
         doff_s = 4'd14;
      end else if (dom >= 5'd20) begin
         dt_s   = 2'd2;
         doff_s = 4'd4;
      end else if (dom >= 5'd10) begin
         dt_s   = 2'd1;
         doff_s = 4'd10;
      end else begin
         dt_s   = 2'd0;
         doff_s = 4'd0;
      end
   end

   // Digit codes, blanked when there is no valid result.
   always_comb begin
      month_tens  = BLANK_CODE;
      month_units = BLANK_CODE;
      dom_tens    = BLANK_CODE;
      dom_units   = BLANK_CODE;
      if (month != 4'd0) begin
         month_tens  = {3'b000, mt_s};
         month_units = month - (mt_s ? 4'd10 : 4'd0);
         dom_tens    = {2'b00, dt_s};
         dom_units   = dom[3:0] - doff_s;
      end else begin
         month_tens  = BLANK_CODE;
         month_units = BLANK_CODE;
         dom_tens    = BLANK_CODE;
         dom_units   = BLANK_CODE;
      end
   end

endmodule

// File: rtl/segment_hex.sv
// ---------------------------------------------------------------------------
// segment_HEX
// Decodes a 4-bit digit code to an active-low 7-segment pattern with the
// decimal point in bit 7 (always off). Codes 0..9 show the digit; every
// other code, including the blank code 4'hF, turns all segments off.
// Ports:
//   code  in  4  digit code
//   seg   out 8  active-low segments {dp, g, f, e, d, c, b, a}
// ---------------------------------------------------------------------------
module segment_HEX (
   input  logic [3:0] code,
   output logic [7:0] seg
);

   // Digit code to segment pattern lookup.
   always_comb begin
      seg = 8'hFF;
      case (code)
         4'd0:    seg = 8'hC0;
         4'd1:    seg = 8'hF9;
         4'd2:    seg = 8'hA4;
         4'd3:    seg = 8'hB0;
         4'd4:    seg = 8'h99;
         4'd5:    seg = 8'h92;
         4'd6:    seg = 8'h82;
         4'd7:    seg = 8'hF8;
         4'd8:    seg = 8'h80;
         4'd9:    seg = 8'h90;
         default: seg = 8'hFF;
      endcase
   end

endmodule

// File: rtl/doy_to_date_seq.sv
// ---------------------------------------------------------------------------
// doy_to_date_seq
// Sequential day-of-year to calendar-date converter. A start in IDLE
// latches day_in/leap_year; the WALK state subtracts one month length per
// clock until the remaining days fit in the current month. Out-of-range
// requests finish in one cycle with err set and blank digits.
// Ports:
//   clk, rst_n       clock (rising edge), async active-low reset
//   start            request a conversion (ignored while busy)
//   day_in           day of year, 1..365 (1..366 in a leap year)
//   leap_year        February has 29 days
//   busy             conversion in progress
//   done             one-cycle pulse when month/dom/err update
//   err              last request was out of range
//   month, dom       binary result month and day-of-month
//   HEX3..HEX0       7-segment digits: month tens/units, dom tens/units
// ---------------------------------------------------------------------------
import doy_pkg::*;

module doy_to_date_seq #(
   parameter int         DAY_W      = 9,
   parameter int         SEG_W      = 8,
   parameter logic [3:0] BLANK_CODE = 4'hF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [DAY_W-1:0] day_in,
   input  logic             leap_year,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [3:0]       month,
   output logic [4:0]       dom,
   output logic [SEG_W-1:0] HEX3,
   output logic [SEG_W-1:0] HEX2,
   output logic [SEG_W-1:0] HEX1,
   output logic [SEG_W-1:0] HEX0
);

   state_t           state_r, state_s;
   logic [DAY_W-1:0] rem_r, rem_s;
   logic             lp_r, lp_s;
   logic [3:0]       m_r, m_s;
   logic             busy_r, busy_s;
   logic             done_r, done_s;
   logic             err_r, err_s;
   logic [3:0]       month_r, month_s;
   logic [4:0]       dom_r, dom_s;

   logic [DAY_W-1:0] len_s;
   logic [DAY_W-1:0] limit_s;
   logic [3:0]       d3_s, d2_s, d1_s, d0_s;

   // Current month length and the last valid day for the requested year.
   always_comb begin
      len_s   = {{(DAY_W-5){1'b0}}, month_len(m_r, lp_r)};
      limit_s = DAY_W'(DAYS_NONLEAP) + {{(DAY_W-1){1'b0}}, leap_year};
   end

   // Next-state and next-output logic for the IDLE/WALK controller.
   always_comb begin
      state_s = state_r;
      rem_s   = rem_r;
      lp_s    = lp_r;
      m_s     = m_r;
      busy_s  = busy_r;
      done_s  = 1'b0;
      err_s   = err_r;
      month_s = month_r;
      dom_s   = dom_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               rem_s = day_in;
               lp_s  = leap_year;
               if ((day_in == {DAY_W{1'b0}}) || (day_in > limit_s)) begin
                  state_s = IDLE;
                  busy_s  = 1'b0;
                  done_s  = 1'b1;
                  err_s   = 1'b1;
                  month_s = 4'd0;
                  dom_s   = 5'd0;
               end else begin
                  state_s = WALK;
                  m_s     = 4'd1;
                  busy_s  = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         WALK: begin
            if (rem_r <= len_s) begin
               state_s = IDLE;
               busy_s  = 1'b0;
               done_s  = 1'b1;
               err_s   = 1'b0;
               month_s = m_r;
               dom_s   = rem_r[4:0];
            end else if (m_r >= 4'd12) begin
               // Past December with days left over: cannot happen for a
               // range-checked request, but never walk into month 13.
               state_s = IDLE;
               busy_s  = 1'b0;
               done_s  = 1'b1;
               err_s   = 1'b1;
               month_s = 4'd0;
               dom_s   = 5'd0;
            end else begin
               rem_s = rem_r - len_s;
               m_s   = m_r + 4'd1;
            end
         end
         default: begin
            state_s = IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end

   // Controller and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         rem_r   <= {DAY_W{1'b0}};
         lp_r    <= 1'b0;
         m_r     <= 4'd0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
         month_r <= 4'd0;
         dom_r   <= 5'd0;
      end else begin
         state_r <= state_s;
         rem_r   <= rem_s;
         lp_r    <= lp_s;
         m_r     <= m_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         err_r   <= err_s;
         month_r <= month_s;
         dom_r   <= dom_s;
      end
   end

   assign busy  = busy_r;
   assign done  = done_r;
   assign err   = err_r;
   assign month = month_r;
   assign dom   = dom_r;

   date_bcd_split #(
      .BLANK_CODE (BLANK_CODE)
   ) u_split (
      .month       (month_r),
      .dom         (dom_r),
      .month_tens  (d3_s),
      .month_units (d2_s),
      .dom_tens    (d1_s),
      .dom_units   (d0_s)
   );

   segment_HEX u_hex3 (.code(d3_s), .seg(HEX3));
   segment_HEX u_hex2 (.code(d2_s), .seg(HEX2));
   segment_HEX u_hex1 (.code(d1_s), .seg(HEX1));
   segment_HEX u_hex0 (.code(d0_s), .seg(HEX0));

endmodule

// File: tb/tb_doy_to_date_seq.sv
// ---------------------------------------------------------------------------
// tb_doy_to_date_seq
// Self-checking bench for doy_to_date_seq. Each request pushes its expected
// month/day/err (from a cumulative-days calendar model) onto a queue; the
// result is popped and compared when done rises. Inputs change on the
// falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_doy_to_date_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic [8:0] day_in = 9'd0;
   logic       leap_year = 1'b0;
   logic       busy, done, err;
   logic [3:0] month;
   logic [4:0] dom;
   logic [7:0] HEX3, HEX2, HEX1, HEX0;

   typedef struct {
      int m;
      int d;
      bit e;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   doy_to_date_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .day_in    (day_in),
      .leap_year (leap_year),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .month     (month),
      .dom       (dom),
      .HEX3      (HEX3),
      .HEX2      (HEX2),
      .HEX1      (HEX1),
      .HEX0      (HEX0)
   );

   always #5 clk = ~clk;

   // Calendar model based on cumulative end-of-month day counts.
   task automatic model(input int day, input bit l, output exp_t r);
      int cum[0:11] = '{0, 31, 59, 90, 120, 151, 181, 212, 243, 273, 304, 334};
      r.e = 1'b0;
      r.m = 0;
      r.d = 0;
      if (day < 1 || day > 365 + int'(l)) begin
         r.e = 1'b1;
      end else begin
         r.m = 1;
         r.d = day;
         for (int k = 1; k < 12; k++) begin
            int c;
            c = cum[k] + ((k >= 2) ? int'(l) : 0);
            if (day > c) begin
               r.m = k + 1;
               r.d = day - c;
            end
         end
      end
   endtask

   function automatic logic [7:0] seg7(input int v);
      case (v)
         0: return 8'hC0;
         1: return 8'hF9;
         2: return 8'hA4;
         3: return 8'hB0;
         4: return 8'h99;
         5: return 8'h92;
         6: return 8'h82;
         7: return 8'hF8;
         8: return 8'h80;
         9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic [31:0] hex_exp(input exp_t r);
      if (r.e) return 32'hFFFF_FFFF;
      return {seg7(r.m / 10), seg7(r.m % 10), seg7(r.d / 10), seg7(r.d % 10)};
   endfunction

   // Called at a falling edge: request a conversion and queue its expectation.
   task automatic send(input int day, input bit l);
      exp_t r;
      model(day, l, r);
      exp_q.push_back(r);
      start     = 1'b1;
      day_in    = 9'(day);
      leap_year = l;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait (bounded) for done; cnt = falling edges waited, b0 = busy at entry.
   task automatic collect(output int cnt, output logic b0);
      cnt = 0;
      b0  = busy;
      while (done !== 1'b1 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, err, month, dom} !== 12'd0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b err=%b month=%0d dom=%0d, want all 0",
                  busy, done, err, month, dom);
      end
      checks++;
      if ({HEX3, HEX2, HEX1, HEX0} !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL reset_digits: got %h, want ffffffff", {HEX3, HEX2, HEX1, HEX0});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_conversions();
      int   days[12]  = '{59, 60, 60, 365, 366, 366, 31, 32, 0, 1, 367, 200};
      bit   leaps[12] = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 1};
      int   cnt;
      logic b0;
      exp_t r;
      for (int i = 0; i < 20; i++) begin
         int d;
         bit l;
         if (i < 12) begin
            d = days[i];
            l = leaps[i];
         end else begin
            d = int'($urandom_range(0, 367));
            l = bit'($urandom_range(0, 1));
         end
         send(d, l);
         collect(cnt, b0);
         r = exp_q.pop_front();
         checks++;
         if ({month, dom, err} !== {4'(r.m), 5'(r.d), r.e}) begin
            errors++;
            $display("FAIL conv_result day=%0d leap=%0d: got %0d/%0d err=%b, want %0d/%0d err=%b",
                     d, l, month, dom, err, r.m, r.d, r.e);
         end
         checks++;
         if (cnt !== (r.e ? 0 : r.m)) begin
            errors++;
            $display("FAIL conv_latency day=%0d leap=%0d: got %0d cycles, want %0d",
                     d, l, cnt, (r.e ? 0 : r.m));
         end
         checks++;
         if ({HEX3, HEX2, HEX1, HEX0} !== hex_exp(r)) begin
            errors++;
            $display("FAIL conv_digits day=%0d leap=%0d: got %h, want %h",
                     d, l, {HEX3, HEX2, HEX1, HEX0}, hex_exp(r));
         end
         checks++;
         if (b0 !== !r.e) begin
            errors++;
            $display("FAIL conv_busy day=%0d leap=%0d: got busy=%b after start, want %b",
                     d, l, b0, !r.e);
         end
         @(negedge clk);
         checks++;
         if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL conv_done_width day=%0d: got done=%b busy=%b, want 0 0", d, done, busy);
         end
      end
   endtask

   task automatic test_busy_ignore();
      int   cnt;
      logic b0;
      int   extra;
      exp_t r;
      send(300, 1'b0);
      start  = 1'b1;
      day_in = 9'd5;
      for (int i = 0; i < 3; i++) begin
         leap_year = ~leap_year;
         @(negedge clk);
      end
      start = 1'b0;
      collect(cnt, b0);
      r = exp_q.pop_front();
      checks++;
      if ({month, dom, err} !== {4'(r.m), 5'(r.d), r.e}) begin
         errors++;
         $display("FAIL busy_ignore_result: got %0d/%0d err=%b, want %0d/%0d err=%b",
                  month, dom, err, r.m, r.d, r.e);
      end
      checks++;
      if (cnt !== 7) begin
         errors++;
         $display("FAIL busy_ignore_latency: got %0d remaining cycles, want 7", cnt);
      end
      checks++;
      if ({HEX3, HEX2, HEX1, HEX0} !== {seg7(1), seg7(0), seg7(2), seg7(7)}) begin
         errors++;
         $display("FAIL busy_ignore_digits: got %h, want digits 1,0,2,7", {HEX3, HEX2, HEX1, HEX0});
      end
      extra = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) extra++;
      end
      checks++;
      if (extra !== 0) begin
         errors++;
         $display("FAIL busy_ignore_no_rerun: got %0d cycles with done/busy, want 0", extra);
      end
   endtask

   task automatic test_back_to_back();
      int   cnt;
      logic b0;
      exp_t r;
      send(100, 1'b0);
      collect(cnt, b0);
      r = exp_q.pop_front();
      checks++;
      if ({month, dom, err} !== {4'(r.m), 5'(r.d), r.e}) begin
         errors++;
         $display("FAIL b2b_first: got %0d/%0d err=%b, want %0d/%0d err=%b",
                  month, dom, err, r.m, r.d, r.e);
      end
      send(45, 1'b1);
      collect(cnt, b0);
      r = exp_q.pop_front();
      checks++;
      if ({month, dom, err} !== {4'(r.m), 5'(r.d), r.e}) begin
         errors++;
         $display("FAIL b2b_second: got %0d/%0d err=%b, want %0d/%0d err=%b",
                  month, dom, err, r.m, r.d, r.e);
      end
      checks++;
      if (cnt !== 2) begin
         errors++;
         $display("FAIL b2b_latency: got %0d cycles, want 2", cnt);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_walk();
      int   cnt;
      logic b0;
      int   seen;
      exp_t r;
      send(330, 1'b0);
      r = exp_q.pop_front();
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, err, month, dom} !== 12'd0) begin
         errors++;
         $display("FAIL midwalk_reset_outputs: got busy=%b done=%b err=%b month=%0d dom=%0d, want all 0",
                  busy, done, err, month, dom);
      end
      checks++;
      if ({HEX3, HEX2, HEX1, HEX0} !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL midwalk_reset_digits: got %h, want ffffffff", {HEX3, HEX2, HEX1, HEX0});
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done !== 1'b0) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL midwalk_no_done: got %0d done cycles after release, want 0", seen);
      end
      send(1, 1'b0);
      collect(cnt, b0);
      r = exp_q.pop_front();
      checks++;
      if ({month, dom, err, cnt} !== {4'd1, 5'd1, 1'b0, 32'd1}) begin
         errors++;
         $display("FAIL midwalk_restart: got %0d/%0d err=%b after %0d cycles, want %0d/%0d err=%b after 1",
                  month, dom, err, cnt, r.m, r.d, r.e);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_conversions();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_walk();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
